mem_responder: RTL

Word-addressed data/instruction memory responder on the CPU side of the address path. It accepts one request at a time from the multicycle control unit, using the selected 32-bit byte address plus size and write data. It performs word, halfword or byte reads and writes, inserting a parameterised number of wait states. It returns read data with a one-cycle `done` pulse, or flags misaligned accesses with `err`. Sub-word stores are performed as an internal read-modify-write.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_lane_merge.sv | 39 +++
 rtl/mem_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the word-addressed memory responder.
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_MERGE,
    ST_DONE
  } state_e;

  // Bytes may sit anywhere; halves need an even address; words need a word-aligned one.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_ILL) ||
           (size == SZ_HALF && off[0]) ||
           (size == SZ_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Little-endian lane extract (zero-extended load) and lane merge (sub-word store).
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [4:0]  sh;
  logic [31:0] shifted;

  assign sh      = {off_i, 3'b000};
  assign shifted = word_i >> sh;

  always_comb begin
    load_o  = 32'h0;
    store_o = word_i;
    case (size_i)
      SZ_WORD: begin
        load_o  = word_i;
        store_o = wdata_i;
      end
      SZ_HALF: begin
        load_o  = {16'h0, shifted[15:0]};
        store_o = (word_i & ~(32'h0000_FFFF << sh)) | ({16'h0, wdata_i[15:0]} << sh);
      end
      SZ_BYTE: begin
        load_o  = {24'h0, shifted[7:0]};
        store_o = (word_i & ~(32'h0000_00FF << sh)) | ({24'h0, wdata_i[7:0]} << sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: latches a request, waits, accesses the
// array (read-modify-write for sub-word stores) and pulses done for one cycle.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     merge_q, merge_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [DEPTH];
  logic            mem_we;
  logic [31:0]     mem_wd;
  logic [AW-1:0]   idx;
  logic [31:0]     rd_word, lane_word, load_word, store_word;
  logic            unused_addr;

  // Upper address bits alias onto the same words, so they are dropped here.
  assign unused_addr = ^addr[31:AW+2];
  assign idx         = addr_q[AW+1:2];
  assign rd_word     = mem_q[idx];
  assign lane_word   = (state_q == ST_MERGE) ? merge_q : rd_word;

  mem_lane_merge u_lane (
    .word_i  (lane_word),
    .wdata_i (wdata_q),
    .off_i   (addr_q[1:0]),
    .size_i  (size_q),
    .load_o  (load_word),
    .store_o (store_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = 32'h0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    mem_wd  = store_word;
    case (state_q)
      ST_IDLE: if (req) begin
        we_d    = we;
        size_d  = size;
        addr_d  = addr[AW+1:0];
        wdata_d = wdata;
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        if (misaligned(size_q, addr_q[1:0])) begin
          err_d = 1'b1;
        end else if (!we_q) begin
          rdata_d = load_word;
        end else if (size_q == SZ_WORD) begin
          mem_we = 1'b1;
          mem_wd = wdata_q;
        end else begin
          merge_d = rd_word;
          done_d  = 1'b0;
          state_d = ST_MERGE;
        end
      end
      ST_MERGE: begin
        mem_we  = 1'b1;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; writes are gated by state, which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= mem_wd;
  end

  assign rdata = rdata_q;
  assign done  = done_q;
  assign err   = err_q;
  assign busy  = (state_q != ST_IDLE);

endmodule
